current_trip_monitor: RTL
=========================

// Module: current_trip_monitor
// PURPOSE
//  Over-current protection stage downstream of the 4-channel ADC reader.
//  Consumes the per-channel 12-bit samples and their 1-cycle valid strobes.
//  Trips a channel after N consecutive over-threshold samples and drops the
//  power enable. Release requires a sample below a hysteresis level plus i_Clear.
// PARAMETERS
//  N_CONSEC        4       consecutive samples >= trip threshold to trip (1..15)
//  STARTUP_CYCLES  1000    i_Clk cycles after reset before o_Power_En may rise
// PORTS
//  i_Clk             in   1   system clock (single clock domain)
//  i_Rst_L           in   1   async active-low reset
//  adc_data_ch0..3   in   12  unsigned ADC sample per channel
//  adc_valid_ch0..3  in   1   1-cycle strobe, data valid same cycle
//  i_Thresh_Trip     in   12  trip level; unsigned, quasi-static
//  i_Thresh_Release  in   12  release level; must be <= i_Thresh_Trip
//  i_Enable_Mask     in   4   bit k=1: channel k monitored
//  i_Clear           in   1   level; request release of tripped channels
//  o_Trip            out  4   bit k=1: channel k latched tripped
//  o_Power_En        out  1   1 = load power allowed
//  o_Trip_Count      out  8   saturating count of trip events
// BEHAVIOUR
//  Reset (async, i_Rst_L=0): o_Trip=0, o_Power_En=0, o_Trip_Count=0.
//   All channel counters=0, below_rel flags=1, startup counter=0, FSMs=MONITOR.
//  Startup: counter increments each cycle, saturates at STARTUP_CYCLES.
//   ready=1 once saturated; samples are still monitored during startup.
//  o_Power_En (registered) = ready & ~|o_Trip.
//   Drops the cycle after a trip registers, i.e. same cycle o_Trip shows it.
//  Per-channel FSM, states MONITOR and TRIPPED; cnt is 4-bit:
//   MONITOR, valid=1 & mask=1:
//    data>=trip: cnt+1; if cnt+1==N_CONSEC -> TRIPPED, o_Trip[k]=1 next cycle, cnt=0.
//    data<trip: cnt=0.
//   MONITOR, mask=0: valid ignored, cnt forced 0.
//   MONITOR, i_Clear=1: cnt forced 0; this overrides a same-cycle sample.
//   TRIPPED: o_Trip[k] held regardless of data or mask.
//    Masking never clears a trip.
//   below_rel[k]: updated on every valid_k, mask-independent; 1 when data<release.
//   TRIPPED & i_Clear=1 & below_rel[k]=1 (registered value, pre-this-cycle
//    sample) -> MONITOR, o_Trip[k]=0 next cycle. below_rel=0: clear ignored.
//  Trip latency: o_Trip[k] rises 1 cycle after the N-th qualifying valid.
//  Simultaneous trips on several channels in one cycle: o_Trip_Count +1 only.
//   It increments once per cycle with >=1 new trip and saturates at 255.
//   Cleared only by reset.
//  No mid-operation hazards. Reset mid-count discards all state immediately.
// TESTING
//  T1 reset, no valids: o_Power_En=0 until cycle STARTUP_CYCLES+1, then 1.
//   o_Trip=0, count=0.
//  T2 trip=3000, ch0 samples 3000,3100,3050,4095 (N=4):
//   o_Trip=4'b0001 1 cycle after 4th valid; o_Power_En=0; count=1.
//  T3 ch1 samples 3500,3500,3500,2000,3500: no trip, cnt resets.
//   Then 3 more at 3500 -> trip on the 4th consecutive.
//  T4 ch0 tripped, release=2500, last sample 2800, i_Clear=1 -> stays tripped.
//   Sample 2400 then i_Clear=1 -> o_Trip[0]=0, o_Power_En=1 next cycle.
//  T5 ch2 & ch3 reach N-th over sample same cycle: o_Trip=4'b1100, count +1.
//   Mask ch3 afterwards: o_Trip[3] stays 1.
//  T6 300 trip/clear cycles: o_Trip_Count saturates at 255.
//   Assert i_Rst_L=0 mid-count: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/current_trip_monitor.sv
// Over-current trip stage: latches a channel after N_CONSEC consecutive samples at or above
// the trip level, gates load power, and counts trip events.
module current_trip_monitor #(
    parameter int N_CONSEC       = 4,
    parameter int STARTUP_CYCLES = 1000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [11:0] adc_data_ch0,
    input  logic [11:0] adc_data_ch1,
    input  logic [11:0] adc_data_ch2,
    input  logic [11:0] adc_data_ch3,
    input  logic        adc_valid_ch0,
    input  logic        adc_valid_ch1,
    input  logic        adc_valid_ch2,
    input  logic        adc_valid_ch3,
    input  logic [11:0] i_Thresh_Trip,
    input  logic [11:0] i_Thresh_Release,
    input  logic [3:0]  i_Enable_Mask,
    input  logic        i_Clear,
    output logic [3:0]  o_Trip,
    output logic        o_Power_En,
    output logic [7:0]  o_Trip_Count
);

    localparam int SW = $clog2(STARTUP_CYCLES + 1);

    typedef enum logic {
        MONITOR = 1'b0,
        TRIPPED = 1'b1
    } state_t;

    state_t      state_q [4];
    state_t      state_d [4];
    logic [3:0]  cnt_q   [4];
    logic [3:0]  cnt_d   [4];
    logic [3:0]  below_rel_q;
    logic [3:0]  below_rel_d;
    logic [3:0]  new_trip;
    logic [3:0]  trip_d;
    logic [11:0] data    [4];
    logic [3:0]  valid;
    logic [SW-1:0] startup_cnt;
    logic        ready;

    assign data[0] = adc_data_ch0;
    assign data[1] = adc_data_ch1;
    assign data[2] = adc_data_ch2;
    assign data[3] = adc_data_ch3;
    assign valid   = {adc_valid_ch3, adc_valid_ch2, adc_valid_ch1, adc_valid_ch0};
    assign ready   = (startup_cnt == SW'(STARTUP_CYCLES));

    always_comb begin
        new_trip    = '0;
        trip_d      = '0;
        below_rel_d = below_rel_q;
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (valid[k]) begin
                below_rel_d[k] = (data[k] < i_Thresh_Release);
            end
            case (state_q[k])
                MONITOR: begin
                    if (i_Clear || !i_Enable_Mask[k]) begin
                        cnt_d[k] = '0;
                    end else if (valid[k]) begin
                        if (data[k] >= i_Thresh_Trip) begin
                            if (({1'b0, cnt_q[k]} + 5'd1) == 5'(N_CONSEC)) begin
                                state_d[k]  = TRIPPED;
                                cnt_d[k]    = '0;
                                new_trip[k] = 1'b1;
                            end else begin
                                cnt_d[k] = cnt_q[k] + 4'd1;
                            end
                        end else begin
                            cnt_d[k] = '0;
                        end
                    end
                end
                TRIPPED: begin
                    cnt_d[k] = '0;
                    // Release uses the flag from earlier samples, not this cycle's sample.
                    if (i_Clear && below_rel_q[k]) begin
                        state_d[k] = MONITOR;
                    end
                end
                default: begin
                    state_d[k] = MONITOR;
                    cnt_d[k]   = '0;
                end
            endcase
            trip_d[k] = (state_d[k] == TRIPPED);
        end
    end

    always_comb begin
        o_Trip = '0;
        for (int k = 0; k < 4; k++) begin
            o_Trip[k] = (state_q[k] == TRIPPED);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= MONITOR;
                cnt_q[k]   <= '0;
            end
            below_rel_q <= '1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            below_rel_q <= below_rel_d;
        end
    end

    // Power follows the next trip state so it drops in the same cycle o_Trip rises.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            startup_cnt  <= '0;
            o_Power_En   <= 1'b0;
            o_Trip_Count <= '0;
        end else begin
            if (!ready) begin
                startup_cnt <= startup_cnt + 1'b1;
            end
            o_Power_En <= ready & ~|trip_d;
            if (|new_trip && (o_Trip_Count != 8'hFF)) begin
                o_Trip_Count <= o_Trip_Count + 8'd1;
            end
        end
    end

endmodule
